id_stage_pipe: RTL and testbench

- Registered, handshaked RV32I decode stage.
- Sits between the instruction-fetch path and EX.
- Decodes every RV32I opcode class and generates sign-extended immediates for all formats (R/I/S/B/U/J).
- Drives register-file read ports and holds one decoded instruction in an ID/EX output register.
- Detects load-use hazards against the instruction it currently holds, supports flush, and uses valid/ready backpressure on both sides.

---
 rtl/id_stage_pipe.sv | 231 +++++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// ============================================================================
// Module      : id_stage_pipe
// Description : Registered RV32I decode stage. It has valid/ready handshakes
//               on both sides, load-use hazard stalling and flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_stage_pipe #(
  parameter int PC_WIDTH = 10,
  parameter int XLEN     = 32,
  parameter int RA_W     = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PC_WIDTH-1:0] in_pc,
  input  logic [31:0]         in_inst,
  input  logic                flush,
  output logic                rs1_re,
  output logic [RA_W-1:0]     rs1_addr,
  input  logic [XLEN-1:0]     rs1_data_i,
  output logic                rs2_re,
  output logic [RA_W-1:0]     rs2_addr,
  input  logic [XLEN-1:0]     rs2_data_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [6:0]          out_opcode,
  output logic [2:0]          out_funct3,
  output logic [6:0]          out_funct7,
  output logic [XLEN-1:0]     out_imm,
  output logic [XLEN-1:0]     out_rs1_data,
  output logic [XLEN-1:0]     out_rs2_data,
  output logic                out_rd_we,
  output logic [RA_W-1:0]     out_rd_addr,
  output logic                out_is_load,
  output logic                out_illegal
);

  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OP_OP     = 7'b0110011;
  localparam logic [6:0] c_OP_FENCE  = 7'b0001111;
  localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [RA_W-1:0] w_rs1;
  logic [RA_W-1:0] w_rs2;
  logic [RA_W-1:0] w_rd;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_imm;
  logic            w_rs1_use;
  logic            w_rs2_use;
  logic            w_rd_use;
  logic            w_rd_we;
  logic            w_is_load;
  logic            w_illegal;
  logic            w_hazard;
  logic            w_accept;

  logic                r_out_valid;
  logic [PC_WIDTH-1:0] r_out_pc;
  logic [6:0]          r_out_opcode;
  logic [2:0]          r_out_funct3;
  logic [6:0]          r_out_funct7;
  logic [XLEN-1:0]     r_out_imm;
  logic [XLEN-1:0]     r_out_rs1_data;
  logic [XLEN-1:0]     r_out_rs2_data;
  logic                r_out_rd_we;
  logic [RA_W-1:0]     r_out_rd_addr;
  logic                r_out_is_load;
  logic                r_out_illegal;

  assign w_opcode = in_inst[6:0];
  assign w_funct3 = in_inst[14:12];
  assign w_funct7 = in_inst[31:25];
  assign w_rs1    = in_inst[19:15];
  assign w_rs2    = in_inst[24:20];
  assign w_rd     = in_inst[11:7];

  assign w_imm_i = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
  assign w_imm_s = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign w_imm_b = {{(XLEN-13){in_inst[31]}}, in_inst[31], in_inst[7],
                    in_inst[30:25], in_inst[11:8], 1'b0};
  assign w_imm_u = {in_inst[31:12], 12'b0};
  assign w_imm_j = {{(XLEN-21){in_inst[31]}}, in_inst[31], in_inst[19:12],
                    in_inst[20], in_inst[30:21], 1'b0};

  always_comb begin
    w_rs1_use = 1'b0;
    w_rs2_use = 1'b0;
    w_rd_use  = 1'b0;
    w_is_load = 1'b0;
    w_illegal = 1'b0;
    w_imm     = '0;
    case (w_opcode)
      c_OP_LUI, c_OP_AUIPC: begin
        w_rd_use = 1'b1;
        w_imm    = w_imm_u;
      end
      c_OP_JAL: begin
        w_rd_use = 1'b1;
        w_imm    = w_imm_j;
      end
      c_OP_JALR: begin
        w_rs1_use = 1'b1;
        w_rd_use  = 1'b1;
        w_imm     = w_imm_i;
      end
      c_OP_BRANCH: begin
        w_rs1_use = 1'b1;
        w_rs2_use = 1'b1;
        w_imm     = w_imm_b;
      end
      c_OP_LOAD: begin
        w_rs1_use = 1'b1;
        w_rd_use  = 1'b1;
        w_is_load = 1'b1;
        w_imm     = w_imm_i;
      end
      c_OP_STORE: begin
        w_rs1_use = 1'b1;
        w_rs2_use = 1'b1;
        w_imm     = w_imm_s;
      end
      c_OP_OPIMM: begin
        w_rs1_use = 1'b1;
        w_rd_use  = 1'b1;
        // Shifts carry a zero-extended shamt; funct7 keeps the SRAI select.
        if (w_funct3 == 3'b001 || w_funct3 == 3'b101)
          w_imm = {{(XLEN-5){1'b0}}, in_inst[24:20]};
        else
          w_imm = w_imm_i;
      end
      c_OP_OP: begin
        w_rs1_use = 1'b1;
        w_rs2_use = 1'b1;
        w_rd_use  = 1'b1;
      end
      c_OP_FENCE: begin
        w_imm = '0;
      end
      c_OP_SYSTEM: begin
        w_rs1_use = ~w_funct3[2];
        w_rd_use  = 1'b1;
        w_imm     = {{(XLEN-12){1'b0}}, in_inst[31:20]};
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  assign w_rd_we  = w_rd_use & (w_rd != '0);
  assign rs1_re   = in_valid & w_rs1_use;
  assign rs2_re   = in_valid & w_rs2_use;
  assign rs1_addr = rs1_re ? w_rs1 : '0;
  assign rs2_addr = rs2_re ? w_rs2 : '0;

  // A held load with rd=x0 has no writeback, so it must never stall a reader of x0.
  assign w_hazard = r_out_valid & r_out_is_load & r_out_rd_we & in_valid &
                    ((rs1_re & (w_rs1 == r_out_rd_addr)) |
                     (rs2_re & (w_rs2 == r_out_rd_addr)));

  assign in_ready = flush | (~w_hazard & (~r_out_valid | out_ready));
  assign w_accept = in_valid & in_ready & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid    <= 1'b0;
      r_out_pc       <= '0;
      r_out_opcode   <= '0;
      r_out_funct3   <= '0;
      r_out_funct7   <= '0;
      r_out_imm      <= '0;
      r_out_rs1_data <= '0;
      r_out_rs2_data <= '0;
      r_out_rd_we    <= 1'b0;
      r_out_rd_addr  <= '0;
      r_out_is_load  <= 1'b0;
      r_out_illegal  <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid    <= 1'b1;
      r_out_pc       <= in_pc;
      r_out_opcode   <= w_opcode;
      r_out_funct3   <= w_funct3;
      r_out_funct7   <= w_funct7;
      r_out_imm      <= w_imm;
      r_out_rs1_data <= rs1_re ? rs1_data_i : '0;
      r_out_rs2_data <= rs2_re ? rs2_data_i : '0;
      r_out_rd_we    <= w_rd_we;
      r_out_rd_addr  <= w_rd_we ? w_rd : '0;
      r_out_is_load  <= w_is_load;
      r_out_illegal  <= w_illegal;
    end else if (out_ready && r_out_valid) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid    = r_out_valid;
  assign out_pc       = r_out_pc;
  assign out_opcode   = r_out_opcode;
  assign out_funct3   = r_out_funct3;
  assign out_funct7   = r_out_funct7;
  assign out_imm      = r_out_imm;
  assign out_rs1_data = r_out_rs1_data;
  assign out_rs2_data = r_out_rs2_data;
  assign out_rd_we    = r_out_rd_we;
  assign out_rd_addr  = r_out_rd_addr;
  assign out_is_load  = r_out_is_load;
  assign out_illegal  = r_out_illegal;

endmodule

`default_nettype wire

// File: tb/tb_id_stage_pipe.sv
// ============================================================================
// Module      : tb_id_stage_pipe
// Description : Directed self-checking bench for id_stage_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_stage_pipe;

  localparam int PC_WIDTH = 10;
  localparam int XLEN     = 32;
  localparam int RA_W     = 5;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [PC_WIDTH-1:0] in_pc;
  logic [31:0]         in_inst;
  logic                flush;
  logic                rs1_re;
  logic [RA_W-1:0]     rs1_addr;
  logic [XLEN-1:0]     rs1_data_i;
  logic                rs2_re;
  logic [RA_W-1:0]     rs2_addr;
  logic [XLEN-1:0]     rs2_data_i;
  logic                out_valid;
  logic                out_ready;
  logic [PC_WIDTH-1:0] out_pc;
  logic [6:0]          out_opcode;
  logic [2:0]          out_funct3;
  logic [6:0]          out_funct7;
  logic [XLEN-1:0]     out_imm;
  logic [XLEN-1:0]     out_rs1_data;
  logic [XLEN-1:0]     out_rs2_data;
  logic                out_rd_we;
  logic [RA_W-1:0]     out_rd_addr;
  logic                out_is_load;
  logic                out_illegal;

  int checks;
  int failures;

  id_stage_pipe #(.PC_WIDTH(PC_WIDTH), .XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .flush(flush),
    .rs1_re(rs1_re), .rs1_addr(rs1_addr), .rs1_data_i(rs1_data_i),
    .rs2_re(rs2_re), .rs2_addr(rs2_addr), .rs2_data_i(rs2_data_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_imm(out_imm), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_rd_we(out_rd_we), .out_rd_addr(out_rd_addr),
    .out_is_load(out_is_load), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file stand-in: the data word tags which port and address were read.
  assign rs1_data_i = 32'hA000_0000 | {27'b0, rs1_addr};
  assign rs2_data_i = 32'hB000_0000 | {27'b0, rs2_addr};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [PC_WIDTH-1:0] pc, input logic [31:0] inst);
    @(negedge clk);
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst;
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_inst  = 32'h0;
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_inst   = 32'h0;
    flush     = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    check("rst_imm", out_imm, 32'h0);
    check("rst_in_ready", {31'b0, in_ready}, 32'h1);
    @(negedge clk);
    rst = 1'b0;

    // ADDI x1,x0,-1
    present(10'h010, 32'hFFF00093);
    check("addi_rs1_re", {31'b0, rs1_re}, 32'h1);
    check("addi_rs1_addr", {27'b0, rs1_addr}, 32'h0);
    check("addi_rs2_re", {31'b0, rs2_re}, 32'h0);
    // BEQ x1,x2,-4
    present(10'h014, 32'hFE208EE3);
    check("addi_valid", {31'b0, out_valid}, 32'h1);
    check("addi_imm", out_imm, 32'hFFFF_FFFF);
    check("addi_rd", {27'b0, out_rd_addr}, 32'h1);
    check("addi_rd_we", {31'b0, out_rd_we}, 32'h1);
    check("addi_pc", {22'b0, out_pc}, 32'h010);
    check("addi_rs1_data", out_rs1_data, 32'hA000_0000);
    check("addi_rs2_data", out_rs2_data, 32'h0);
    check("beq_rs1_addr", {27'b0, rs1_addr}, 32'h1);
    check("beq_rs2_addr", {27'b0, rs2_addr}, 32'h2);
    // JAL x1,+2048
    present(10'h018, 32'h001000EF);
    check("beq_imm", out_imm, 32'hFFFF_FFFC);
    check("beq_rd_we", {31'b0, out_rd_we}, 32'h0);
    check("beq_rd", {27'b0, out_rd_addr}, 32'h0);
    check("beq_rs1_data", out_rs1_data, 32'hA000_0001);
    check("beq_rs2_data", out_rs2_data, 32'hB000_0002);
    check("jal_rs1_re", {31'b0, rs1_re}, 32'h0);
    idle();
    check("jal_imm", out_imm, 32'h0000_0800);
    check("jal_rd_we", {31'b0, out_rd_we}, 32'h1);
    check("jal_rd", {27'b0, out_rd_addr}, 32'h1);

    // Load-use: LW x5,0(x1) then ADD x6,x5,x2
    present(10'h020, 32'h0000A283);
    present(10'h024, 32'h00228333);
    check("lw_is_load", {31'b0, out_is_load}, 32'h1);
    check("lw_rd", {27'b0, out_rd_addr}, 32'h5);
    check("hz_in_ready", {31'b0, in_ready}, 32'h0);
    @(negedge clk); #1;
    check("hz_bubble", {31'b0, out_valid}, 32'h0);
    check("hz_in_ready_rel", {31'b0, in_ready}, 32'h1);
    idle();
    check("hz_add_valid", {31'b0, out_valid}, 32'h1);
    check("hz_add_pc", {22'b0, out_pc}, 32'h024);
    check("hz_add_rd", {27'b0, out_rd_addr}, 32'h6);
    check("hz_add_rs1_data", out_rs1_data, 32'hA000_0005);

    // No dependency: LW x5 then ADD x6,x3,x2
    present(10'h030, 32'h0000A283);
    present(10'h034, 32'h00218333);
    check("nohz_in_ready", {31'b0, in_ready}, 32'h1);
    idle();
    check("nohz_valid", {31'b0, out_valid}, 32'h1);
    check("nohz_pc", {22'b0, out_pc}, 32'h034);

    // Backpressure: SW x2,-8(x1) held while EX stalls, LUI waiting
    present(10'h040, 32'hFE20AC23);
    @(negedge clk);
    out_ready = 1'b0;
    in_pc     = 10'h044;
    in_inst   = 32'h12345137;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", {31'b0, in_ready}, 32'h0);
      check("bp_pc", {22'b0, out_pc}, 32'h040);
      check("bp_imm", out_imm, 32'hFFFF_FFF8);
      check("bp_valid", {31'b0, out_valid}, 32'h1);
      @(negedge clk);
    end
    check("sw_rs2_data", out_rs2_data, 32'hB000_0002);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'b0, in_ready}, 32'h1);
    idle();
    check("lui_pc", {22'b0, out_pc}, 32'h044);
    check("lui_imm", out_imm, 32'h1234_5000);
    check("lui_rd", {27'b0, out_rd_addr}, 32'h2);

    // Flush with a held and an incoming instruction (SRAI x3,x4,7)
    present(10'h048, 32'h12345137);
    present(10'h04C, 32'h40725193);
    out_ready = 1'b0;
    flush     = 1'b1;
    #1;
    check("fl_in_ready", {31'b0, in_ready}, 32'h1);
    @(negedge clk);
    flush     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    #1;
    check("fl_valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk); #1;
    check("fl_dropped", {31'b0, out_valid}, 32'h0);
    present(10'h04C, 32'h40725193);
    idle();
    check("srai_imm", out_imm, 32'h0000_0007);
    check("srai_funct7", {25'b0, out_funct7}, 32'h20);
    check("srai_funct3", {29'b0, out_funct3}, 32'h5);

    // Unsupported opcode 0x7F
    present(10'h050, 32'h1234507F);
    check("ill_rs1_re", {31'b0, rs1_re}, 32'h0);
    check("ill_rs2_re", {31'b0, rs2_re}, 32'h0);
    idle();
    check("ill_flag", {31'b0, out_illegal}, 32'h1);
    check("ill_rd_we", {31'b0, out_rd_we}, 32'h0);
    check("ill_imm", out_imm, 32'h0);
    check("ill_rs1_data", out_rs1_data, 32'h0);

    // Asynchronous reset while an instruction is held
    present(10'h054, 32'h12345137);
    idle();
    check("pre_rst_valid", {31'b0, out_valid}, 32'h1);
    out_ready = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("arst_valid", {31'b0, out_valid}, 32'h0);
    check("arst_imm", out_imm, 32'h0);
    check("arst_pc", {22'b0, out_pc}, 32'h0);
    check("arst_rd", {27'b0, out_rd_addr}, 32'h0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    // SLLI x1,x1,5
    present(10'h058, 32'h00509093);
    idle();
    check("slli_valid", {31'b0, out_valid}, 32'h1);
    check("slli_imm", out_imm, 32'h0000_0005);
    check("slli_rs1_data", out_rs1_data, 32'hA000_0001);
    check("slli_rd", {27'b0, out_rd_addr}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
